// File: rtl/keypad_scanner.sv
// 3x4 matrix keypad scanner: one-hot column drive, per-frame row analysis and a
// press/release debounce FSM producing registered key pulses.
module keypad_scanner #(
  parameter int DEBOUNCE_SCANS = 4,
  parameter int SCAN_DWELL     = 1
) (
  input  logic       clk_1,
  input  logic       rst,
  input  logic [3:0] key_row,
  output logic [2:0] key_col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       keypad_1,
  output logic       keypad_2,
  output logic       keypad_3,
  output logic       keypad_0,
  output logic       multi_err
);

  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_t;

  // Key code for a single hit at (row, col); row 3 holds *, 0, #.
  function automatic logic [3:0] code_of(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    if (row == 2'd3) begin
      case (col)
        2'd0:    code = 4'd10;
        2'd1:    code = 4'd0;
        default: code = 4'd11;
      endcase
    end else begin
      code = 4'({2'b00, row} * 4'd3 + {2'b00, col} + 4'd1);
    end
    return code;
  endfunction

  // Inverse map: {row, col} of a key code.
  function automatic logic [3:0] pos_of(input logic [3:0] code);
    logic [3:0] pos;
    case (code)
      4'd1:    pos = {2'd0, 2'd0};
      4'd2:    pos = {2'd0, 2'd1};
      4'd3:    pos = {2'd0, 2'd2};
      4'd4:    pos = {2'd1, 2'd0};
      4'd5:    pos = {2'd1, 2'd1};
      4'd6:    pos = {2'd1, 2'd2};
      4'd7:    pos = {2'd2, 2'd0};
      4'd8:    pos = {2'd2, 2'd1};
      4'd9:    pos = {2'd2, 2'd2};
      4'd10:   pos = {2'd3, 2'd0};
      4'd11:   pos = {2'd3, 2'd2};
      default: pos = {2'd3, 2'd1};
    endcase
    return pos;
  endfunction

  localparam logic [3:0] DWELL_LAST = 4'(SCAN_DWELL - 1);
  localparam logic [3:0] DEB_N      = 4'(DEBOUNCE_SCANS);

  logic [3:0] dwell_cnt;
  logic [1:0] col_idx;
  logic       sample, frame_end;

  assign sample    = (dwell_cnt == DWELL_LAST);
  assign frame_end = sample && (col_idx == 2'd2);

  // NOTE: async active-low reset sits in the sensitivity list; every state
  // element gets a defined value while rst is low.
  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) begin
      dwell_cnt <= '0;
      col_idx   <= '0;
    end else if (sample) begin
      // NOTE: non-blocking assignments keep all registers updating from
      // pre-edge values, independent of statement order.
      dwell_cnt <= '0;
      col_idx   <= (col_idx == 2'd2) ? 2'd0 : col_idx + 2'd1;
    end else begin
      dwell_cnt <= dwell_cnt + 4'd1;
    end
  end

  always_comb begin
    case (col_idx)
      2'd1:    key_col = 3'b010;
      2'd2:    key_col = 3'b100;
      default: key_col = 3'b001;
    endcase
  end

  // Per-column analysis merged with what earlier columns of this frame saw.
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d, cand_q, cand_d;
  logic [2:0] cur_hits, sum_hits;
  logic [1:0] row_idx, acc_hits, tot_hits;
  logic [3:0] acc_code, tot_code, cand_pos;
  logic       acc_cand, tot_cand;

  assign cand_pos = pos_of(cand_q);

  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latches).
    cur_hits = 3'($countones(key_row));
    row_idx  = 2'd3;
    case (key_row)
      4'b0001: row_idx = 2'd0;
      4'b0010: row_idx = 2'd1;
      4'b0100: row_idx = 2'd2;
      default: row_idx = 2'd3;
    endcase
    sum_hits = {1'b0, acc_hits} + ((cur_hits > 3'd2) ? 3'd2 : cur_hits);
    tot_hits = (sum_hits > 3'd2) ? 2'd2 : sum_hits[1:0];
    tot_code = (cur_hits != 3'd0) ? code_of(row_idx, col_idx) : acc_code;
    tot_cand = acc_cand || ((col_idx == cand_pos[1:0]) && key_row[cand_pos[3:2]]);
  end

  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) begin
      acc_hits <= '0;
      acc_code <= '0;
      acc_cand <= 1'b0;
    end else if (sample) begin
      if (col_idx == 2'd2) begin
        acc_hits <= '0;
        acc_code <= '0;
        acc_cand <= 1'b0;
      end else begin
        acc_hits <= tot_hits;
        acc_code <= tot_code;
        acc_cand <= tot_cand;
      end
    end
  end

  logic       valid_d, merr_d;
  logic [3:0] cnt_inc;

  assign cnt_inc = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    valid_d = 1'b0;
    merr_d  = 1'b0;
    if (frame_end) begin
      case (state_q)
        IDLE: begin
          if (tot_hits == 2'd1) begin
            state_d = PRESS_CHK;
            cand_d  = tot_code;
            cnt_d   = 4'd1;
          end else if (tot_hits == 2'd2) begin
            merr_d = 1'b1;
          end
        end
        PRESS_CHK: begin
          if (tot_hits == 2'd1 && tot_code == cand_q) begin
            if (cnt_inc >= DEB_N) begin
              state_d = HELD;
              cnt_d   = '0;
              valid_d = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        HELD: begin
          if (!tot_cand) begin
            state_d = REL_CHK;
            cnt_d   = 4'd1;
          end
        end
        default: begin
          if (tot_cand) begin
            state_d = HELD;
            cnt_d   = '0;
          end else if (cnt_inc >= DEB_N) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cand_q    <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      multi_err <= 1'b0;
      keypad_1  <= 1'b0;
      keypad_2  <= 1'b0;
      keypad_3  <= 1'b0;
      keypad_0  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cand_q    <= cand_d;
      key_valid <= valid_d;
      multi_err <= merr_d;
      keypad_1  <= valid_d && (cand_q == 4'd1);
      keypad_2  <= valid_d && (cand_q == 4'd2);
      keypad_3  <= valid_d && (cand_q == 4'd3);
      keypad_0  <= valid_d && (cand_q == 4'd0);
      if (valid_d) key_code <= cand_q;
    end
  end

  assign key_held = (state_q == HELD) || (state_q == REL_CHK);

endmodule
